// File: rtl/evr_tod_event_sequencer.sv
// Time-of-day event scheduler for the EVR event-code stream.
// Emits 0x7d followed by 32 seconds bits, MSB first, and shares the code slot with user events.
//
// state   | meaning
// S_IDLE  | no sequence in progress
// S_LATCH | 0x7d on the stream; bit 0 is due
// S_SHIFT | next seconds bit is due
// S_GAP   | spacing between bits
// S_LAST  | bit 31 on the stream
// S_DONE  | done pulse, still busy
module evr_tod_event_sequencer #(
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned MAX_DEFER  = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        pps_strobe_i,
    input  logic [31:0] seconds_i,
    input  logic        user_valid_i,
    input  logic [7:0]  user_code_i,
    output logic        user_ack_o,
    output logic        user_dropped_o,
    output logic [7:0]  event_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        overrun_o,
    input  logic        overrun_clear_i
);
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned DW = $clog2(MAX_DEFER + 1);

    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_SHIFT, S_GAP, S_LAST, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [31:0]     shift_q, shift_d;
    logic [4:0]      bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [DW-1:0]   defer_q, defer_d;
    logic [7:0]      event_q, event_d;
    logic            dropped_q, dropped_d;
    logic            overrun_q, overrun_d;
    logic            start, bit_due, reserved, emit_bit, user_ack;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_q     <= '0;
            defer_q   <= '0;
            event_q   <= 8'h00;
            dropped_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_q     <= gap_d;
            defer_q   <= defer_d;
            event_q   <= event_d;
            dropped_q <= dropped_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_d     = gap_q;
        defer_d   = defer_q;
        event_d   = 8'h00;
        dropped_d = 1'b0;
        overrun_d = overrun_q & ~overrun_clear_i;
        emit_bit  = 1'b0;
        user_ack  = 1'b0;

        start    = pps_strobe_i & enable_i;
        bit_due  = (state_q == S_LATCH) || (state_q == S_SHIFT);
        reserved = (user_code_i == 8'h70) || (user_code_i == 8'h71) || (user_code_i == 8'h7d);

        case (state_q)
            S_LATCH: state_d = S_SHIFT;
            S_GAP: begin
                if (gap_q == '0) state_d = S_SHIFT;
                else             gap_d   = gap_q - GW'(1);
            end
            S_LAST:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: ;
        endcase

        // Arbitration, highest priority first.
        if (start) begin
            event_d   = 8'h7d;
            state_d   = S_LATCH;
            shift_d   = seconds_i;
            bit_cnt_d = '0;
            defer_d   = '0;
            if (state_q != S_IDLE) overrun_d = 1'b1;
        end else if (bit_due && (defer_q == DW'(MAX_DEFER))) begin
            emit_bit = 1'b1;
        end else if (user_valid_i) begin
            user_ack = 1'b1;
            if (reserved) begin
                dropped_d = 1'b1;
                emit_bit  = bit_due;
            end else begin
                event_d = user_code_i;
                if (bit_due) defer_d = defer_q + DW'(1);
            end
        end else if (bit_due) begin
            emit_bit = 1'b1;
        end

        if (emit_bit) begin
            event_d   = {7'b0111000, shift_q[31]};
            shift_d   = {shift_q[30:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 5'd1;
            defer_d   = '0;
            if (bit_cnt_q == 5'd31) begin
                state_d = S_LAST;
            end else if (GAP_CYCLES == 0) begin
                state_d = S_SHIFT;
            end else begin
                state_d = S_GAP;
                gap_d   = GW'(GAP_CYCLES - 1);
            end
        end
    end

    assign user_ack_o     = user_ack;
    assign user_dropped_o = dropped_q;
    assign event_o        = event_q;
    assign busy_o         = (state_q != S_IDLE);
    assign done_o         = (state_q == S_DONE);
    assign overrun_o      = overrun_q;
endmodule
